// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit 5-stage CPU: captures decoded fields,
// forwards operands from EX/MEM and MEM/WB, and detects load-use hazards.
module id_ex_stage #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [2:0]         id_alu_op,
    input  logic [3:0]         id_shamt,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_use_imm,
    input  logic [1:0]         id_reads,
    input  logic [3:0]         id_ctrl,
    input  logic               fwd_mem_we,
    input  logic [RADDR_W-1:0] fwd_mem_rd,
    input  logic [DATA_W-1:0]  fwd_mem_data,
    input  logic               fwd_wb_we,
    input  logic [RADDR_W-1:0] fwd_wb_rd,
    input  logic [DATA_W-1:0]  fwd_wb_data,
    input  logic               hold,
    input  logic               flush,
    output logic               ex_valid,
    output logic [2:0]         ex_alu_op,
    output logic [3:0]         ex_shamt,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [3:0]         ex_ctrl,
    output logic [DATA_W-1:0]  ex_alu_a,
    output logic [DATA_W-1:0]  ex_alu_b,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic               stall_id
);

    logic [3:0]         ctrl_q;
    logic [RADDR_W-1:0] rs_q, rt_q;
    logic [1:0]         reads_q;
    logic [DATA_W-1:0]  rs_data_q, rt_data_q, imm_q;
    logic               use_imm_q;

    logic               load_use;
    logic [DATA_W-1:0]  rs_cap, rt_cap;
    logic [DATA_W-1:0]  rs_fwd, rt_fwd;

    assign ex_ctrl = ex_valid ? ctrl_q : '0;

    always_comb begin
        load_use = id_valid & ex_valid & ex_ctrl[1] & (ex_rd != '0) &
                   ((id_reads[0] & (id_rs == ex_rd)) | (id_reads[1] & (id_rt == ex_rd)));
        stall_id = hold | (load_use & ~flush);
    end

    // The register file writes in the same cycle MEM/WB presents its result,
    // so the read data seen in ID may be stale; take the writeback value instead.
    always_comb begin
        rs_cap = id_rs_data;
        rt_cap = id_rt_data;
        if (fwd_wb_we && fwd_wb_rd != '0 && fwd_wb_rd == id_rs) rs_cap = fwd_wb_data;
        if (fwd_wb_we && fwd_wb_rd != '0 && fwd_wb_rd == id_rt) rt_cap = fwd_wb_data;
    end

    always_comb begin
        rs_fwd = rs_data_q;
        if (reads_q[0] && rs_q != '0) begin
            if (fwd_mem_we && fwd_mem_rd == rs_q)     rs_fwd = fwd_mem_data;
            else if (fwd_wb_we && fwd_wb_rd == rs_q)  rs_fwd = fwd_wb_data;
        end
        rt_fwd = rt_data_q;
        if (reads_q[1] && rt_q != '0) begin
            if (fwd_mem_we && fwd_mem_rd == rt_q)     rt_fwd = fwd_mem_data;
            else if (fwd_wb_we && fwd_wb_rd == rt_q)  rt_fwd = fwd_wb_data;
        end
        ex_alu_a      = rs_fwd;
        ex_alu_b      = use_imm_q ? imm_q : rt_fwd;
        ex_store_data = rt_fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_alu_op <= '0;
            ex_shamt  <= '0;
            ex_rd     <= '0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            reads_q   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
        end else if (hold) begin
            ex_valid  <= ex_valid;
        end else if (flush || load_use) begin
            ex_valid  <= 1'b0;
            ex_alu_op <= '0;
            ex_shamt  <= '0;
            ex_rd     <= '0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            reads_q   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
        end else begin
            ex_valid  <= id_valid;
            ex_alu_op <= id_alu_op;
            ex_shamt  <= id_shamt;
            ex_rd     <= id_rd;
            ctrl_q    <= id_ctrl;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            reads_q   <= id_reads;
            rs_data_q <= rs_cap;
            rt_data_q <= rt_cap;
            imm_q     <= id_imm;
            use_imm_q <= id_use_imm;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_alu_op;
    logic [3:0]  id_shamt;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm;
    logic [1:0]  id_reads;
    logic [3:0]  id_ctrl;
    logic        fwd_mem_we, fwd_wb_we;
    logic [3:0]  fwd_mem_rd, fwd_wb_rd;
    logic [15:0] fwd_mem_data, fwd_wb_data;
    logic        hold, flush;
    logic        ex_valid;
    logic [2:0]  ex_alu_op;
    logic [3:0]  ex_shamt, ex_rd, ex_ctrl;
    logic [15:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic        stall_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(16), .RADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_reads(id_reads), .id_ctrl(id_ctrl),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_shamt(ex_shamt), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
        .ex_store_data(ex_store_data), .stall_id(stall_id)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic clear_fwd();
        fwd_mem_we = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_we  = 0; fwd_wb_rd  = 0; fwd_wb_data  = 0;
    endtask

    task automatic set_id(input logic v, input logic [2:0] op, input logic [3:0] sh,
                          input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                          input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                          input logic ui, input logic [1:0] rds, input logic [3:0] ctl);
        id_valid = v; id_alu_op = op; id_shamt = sh;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_use_imm = ui; id_reads = rds; id_ctrl = ctl;
        clear_fwd();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; hold = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        rst_n = 1;
        step();
        check_eq("rst_valid", {15'd0, ex_valid}, 16'd0);
        check_eq("rst_ctrl", {12'd0, ex_ctrl}, 16'd0);

        // ADD r1 <- r2 + r3
        set_id(1, 3'd0, 0, 4'd2, 4'd3, 4'd1, 16'h0005, 16'h0006, 0, 0, 2'b11, 4'b0001);
        step();
        check_eq("add_valid", {15'd0, ex_valid}, 16'd1);
        check_eq("add_rd", {12'd0, ex_rd}, 16'd1);
        check_eq("add_a", ex_alu_a, 16'h0005);
        check_eq("add_b", ex_alu_b, 16'h0006);

        // SUB r4 <- r1 - r5 with r1 forwarded from EX/MEM
        set_id(1, 3'd1, 0, 4'd1, 4'd5, 4'd4, 16'h0000, 16'h0003, 0, 0, 2'b11, 4'b0001);
        step();
        fwd_mem_we = 1; fwd_mem_rd = 1; fwd_mem_data = 16'h7FFF;
        #1;
        check_eq("sub_op", {13'd0, ex_alu_op}, 16'd1);
        check_eq("sub_a_fwd_mem", ex_alu_a, 16'h7FFF);
        check_eq("sub_b", ex_alu_b, 16'h0003);

        // XOR with immediate, only rs read
        set_id(1, 3'd3, 0, 4'd2, 4'd6, 4'd7, 16'hAAAA, 16'h0F0F, 16'h0040, 1, 2'b01, 4'b0001);
        step();
        fwd_mem_we = 1; fwd_mem_rd = 2; fwd_mem_data = 16'h1111;
        fwd_wb_we  = 1; fwd_wb_rd  = 2; fwd_wb_data  = 16'h2222;
        #1;
        check_eq("dual_a_mem_wins", ex_alu_a, 16'h1111);
        check_eq("imm_b", ex_alu_b, 16'h0040);
        fwd_mem_rd = 3;
        #1;
        check_eq("wb_only_a", ex_alu_a, 16'h2222);
        fwd_mem_rd = 6; fwd_wb_rd = 6;
        #1;
        check_eq("no_match_a", ex_alu_a, 16'hAAAA);
        check_eq("rt_unread_store", ex_store_data, 16'h0F0F);

        // Register 0 never forwards
        set_id(1, 3'd0, 0, 4'd0, 4'd0, 4'd8, 16'h0000, 16'h0000, 0, 0, 2'b11, 4'b0001);
        step();
        fwd_mem_we = 1; fwd_mem_rd = 0; fwd_mem_data = 16'h1111;
        fwd_wb_we  = 1; fwd_wb_rd  = 0; fwd_wb_data  = 16'h2222;
        #1;
        check_eq("r0_a", ex_alu_a, 16'h0000);
        check_eq("r0_b", ex_alu_b, 16'h0000);

        // LW r3 then dependent ADD r4 <- r3 + r1
        set_id(1, 3'd0, 0, 4'd2, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004, 1, 2'b01, 4'b0011);
        step();
        check_eq("lw_ctrl", {12'd0, ex_ctrl}, 16'h0003);
        check_eq("lw_a", ex_alu_a, 16'h0100);
        set_id(1, 3'd0, 0, 4'd3, 4'd1, 4'd4, 16'h0000, 16'h0010, 0, 0, 2'b11, 4'b0001);
        #1;
        check_eq("lu_stall", {15'd0, stall_id}, 16'd1);
        step();
        check_eq("lu_bubble_valid", {15'd0, ex_valid}, 16'd0);
        check_eq("lu_bubble_ctrl", {12'd0, ex_ctrl}, 16'd0);
        check_eq("lu_stall_clear", {15'd0, stall_id}, 16'd0);
        step();
        fwd_wb_we = 1; fwd_wb_rd = 3; fwd_wb_data = 16'hBEEF;
        #1;
        check_eq("dep_valid", {15'd0, ex_valid}, 16'd1);
        check_eq("dep_a_fwd_wb", ex_alu_a, 16'hBEEF);
        check_eq("dep_b", ex_alu_b, 16'h0010);

        // Flush during load-use
        set_id(1, 3'd0, 0, 4'd2, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004, 1, 2'b01, 4'b0011);
        step();
        set_id(1, 3'd0, 0, 4'd3, 4'd1, 4'd4, 16'h0000, 16'h0010, 0, 0, 2'b11, 4'b0001);
        flush = 1;
        #1;
        check_eq("flush_lu_stall", {15'd0, stall_id}, 16'd0);
        step();
        flush = 0;
        check_eq("flush_valid", {15'd0, ex_valid}, 16'd0);
        check_eq("flush_ctrl", {12'd0, ex_ctrl}, 16'd0);

        // Hold for three cycles, with a flush arriving in the middle one
        set_id(1, 3'd7, 4'd9, 4'd4, 4'd5, 4'd6, 16'h1234, 16'h5678, 0, 0, 2'b11, 4'b1001);
        step();
        check_eq("sra_shamt", {12'd0, ex_shamt}, 16'd9);
        set_id(1, 3'd2, 4'd1, 4'd7, 4'd8, 4'd9, 16'h9999, 16'h8888, 0, 0, 2'b11, 4'b0001);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            #1;
            check_eq("hold_stall", {15'd0, stall_id}, 16'd1);
            step();
            check_eq("hold_op", {13'd0, ex_alu_op}, 16'd7);
            check_eq("hold_ctrl", {12'd0, ex_ctrl}, 16'h0009);
            check_eq("hold_a", ex_alu_a, 16'h1234);
        end
        hold = 0; flush = 0;

        // Capture-time bypass from MEM/WB for a stale register-file read
        set_id(1, 3'd0, 0, 4'd5, 4'd5, 4'd9, 16'h0001, 16'h0001, 0, 0, 2'b11, 4'b0001);
        fwd_wb_we = 1; fwd_wb_rd = 5; fwd_wb_data = 16'h8000;
        step();
        clear_fwd();
        #1;
        check_eq("cap_bypass_a", ex_alu_a, 16'h8000);
        check_eq("cap_bypass_b", ex_alu_b, 16'h8000);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 0;
        #1;
        check_eq("async_rst_valid", {15'd0, ex_valid}, 16'd0);
        check_eq("async_rst_ctrl", {12'd0, ex_ctrl}, 16'd0);
        check_eq("async_rst_a", ex_alu_a, 16'h0000);
        check_eq("async_rst_b", ex_alu_b, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
